// File: rtl/hazard_ctrl_if.sv
// Pipeline hazard-control bundle: ID/EX hazard inputs, memory status and the
// stall/flush/bubble controls plus performance counters.
interface hazard_ctrl_if;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic        id_uses_rs2;
  logic [4:0]  ex_rd;
  logic        ex_mem_read;
  logic        beq_pc_Sel;
  logic        mem_busy;

  logic        pc_write;
  logic        if_id_write;
  logic        ctrl_sgnl_sel;
  logic        If_id_flush;
  logic        pipe_hold;
  logic        mem_timeout;
  logic [15:0] stall_cnt;
  logic [15:0] flush_cnt;

  modport master (
    output id_rs1, id_rs2, id_uses_rs2, ex_rd, ex_mem_read, beq_pc_Sel, mem_busy,
    input  pc_write, if_id_write, ctrl_sgnl_sel, If_id_flush, pipe_hold,
           mem_timeout, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_rs1, id_rs2, id_uses_rs2, ex_rd, ex_mem_read, beq_pc_Sel, mem_busy,
    output pc_write, if_id_write, ctrl_sgnl_sel, If_id_flush, pipe_hold,
           mem_timeout, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use bubbles, taken-branch flushes, memory
// freeze with wait timeout, and saturating stall/flush counters.
//
// state        | meaning
// ST_RUN       | normal flow; load-use / branch / mem_busy resolved combinationally
// ST_MEM_WAIT  | memory busy, pipeline frozen, r_wcnt counts wait cycles
// ST_ERROR     | memory wait exceeded WAIT_MAX; frozen until rst
module hazard_ctrl #(
  parameter int WAIT_MAX = 255
) (
  input  logic         clk,
  input  logic         rst,
  hazard_ctrl_if.slave hz
);

  localparam logic [7:0]  WAIT_MAX_C = WAIT_MAX[7:0];
  localparam logic [15:0] CNT_SAT    = 16'hFFFF;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_ERROR    = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  state_t      w_state_eff;
  logic [7:0]  r_wcnt;
  logic [7:0]  w_wcnt_nxt;
  logic [15:0] r_stall_cnt;
  logic [15:0] r_flush_cnt;

  logic        w_load_use;
  logic        w_pc_write;
  logic        w_if_id_write;
  logic        w_ctrl_sel;
  logic        w_flush;
  logic        w_hold;
  logic        w_timeout;
  logic        w_stall_inc;
  logic        w_flush_inc;

  // While rst is high the outputs behave as in RUN, whatever the stored state.
  assign w_state_eff = rst ? ST_RUN : r_state;

  assign w_load_use = hz.ex_mem_read && (hz.ex_rd != 5'd0) &&
                      ((hz.ex_rd == hz.id_rs1) ||
                       (hz.id_uses_rs2 && (hz.ex_rd == hz.id_rs2)));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_RUN;
      r_wcnt  <= 8'd0;
    end else begin
      r_state <= w_state_nxt;
      r_wcnt  <= w_wcnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_wcnt_nxt    = r_wcnt;
    w_pc_write    = 1'b1;
    w_if_id_write = 1'b1;
    w_ctrl_sel    = 1'b1;
    w_flush       = 1'b0;
    w_hold        = 1'b0;
    w_timeout     = 1'b0;

    case (w_state_eff)
      ST_ERROR: begin
        w_pc_write    = 1'b0;
        w_if_id_write = 1'b0;
        w_ctrl_sel    = 1'b0;
        w_hold        = 1'b1;
        w_timeout     = 1'b1;
        w_state_nxt   = ST_ERROR;
      end

      ST_RUN, ST_MEM_WAIT: begin
        if (hz.mem_busy) begin
          w_pc_write    = 1'b0;
          w_if_id_write = 1'b0;
          w_hold        = 1'b1;
          if (w_state_eff == ST_RUN) begin
            w_state_nxt = ST_MEM_WAIT;
            w_wcnt_nxt  = 8'd1;
          end else if (r_wcnt == WAIT_MAX_C) begin
            w_state_nxt = ST_ERROR;
          end else begin
            w_wcnt_nxt  = r_wcnt + 8'd1;
          end
        end else begin
          w_state_nxt = ST_RUN;
          w_wcnt_nxt  = 8'd0;
          // A taken branch squashes the ID instruction, so its load-use stall is moot.
          if (hz.beq_pc_Sel) begin
            w_flush    = 1'b1;
            w_ctrl_sel = 1'b0;
          end else if (w_load_use) begin
            w_pc_write    = 1'b0;
            w_if_id_write = 1'b0;
            w_ctrl_sel    = 1'b0;
          end
        end
      end

      default: begin
        w_state_nxt = ST_RUN;
        w_wcnt_nxt  = 8'd0;
      end
    endcase
  end

  assign w_stall_inc = !w_pc_write && (w_state_eff != ST_ERROR) && (r_stall_cnt != CNT_SAT);
  assign w_flush_inc = w_flush && (r_flush_cnt != CNT_SAT);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= 16'd0;
      r_flush_cnt <= 16'd0;
    end else begin
      if (w_stall_inc) r_stall_cnt <= r_stall_cnt + 16'd1;
      if (w_flush_inc) r_flush_cnt <= r_flush_cnt + 16'd1;
    end
  end

  assign hz.pc_write      = w_pc_write;
  assign hz.if_id_write   = w_if_id_write;
  assign hz.ctrl_sgnl_sel = w_ctrl_sel;
  assign hz.If_id_flush   = w_flush;
  assign hz.pipe_hold     = w_hold;
  assign hz.mem_timeout   = w_timeout;
  assign hz.stall_cnt     = r_stall_cnt;
  assign hz.flush_cnt     = r_flush_cnt;

endmodule
